// File: rtl/img_sdram_writer_if.sv
// Pixel-in / SDRAM-write-out bundle for img_sdram_writer.
// master: the writer block (sinks CPU pixels, drives SDRAM write port 2).
// slave : the surrounding system (CPU pixel bridge + SDRAM write FIFO).
// Handshake: a pixel moves on a rising clk edge where pixel_valid and
// pixel_ready are both high; wr_req is a one-cycle strobe with wr_data valid
// in the same cycle and is only raised for an edge that sampled wr_full low.
`timescale 1ns/1ps
interface img_sdram_writer_if;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic        pixel_ready;
    logic        wr_full;
    logic        wr_req;
    logic [15:0] wr_data;

    modport master (
        input  pixel_valid, pixel_data, wr_full,
        output pixel_ready, wr_req, wr_data
    );

    modport slave (
        output pixel_valid, pixel_data, wr_full,
        input  pixel_ready, wr_req, wr_data
    );
endinterface

// File: rtl/img_sdram_writer.sv
// img_sdram_writer: packs CPU RGB pixels into 16-bit words and writes them
// linearly to SDRAM write port 2 from start_addr up to (not including)
// max_addr, flagging every wr_len-word burst with burst_done.
// Build option IMG_WR_RGB888_EN: when defined each pixel becomes two words
// ({R,G} then {B,8'h00}); when undefined each pixel becomes one RGB565 word.
// All outputs are registers; curr_state exposes the FSM for debug.
`timescale 1ns/1ps
module img_sdram_writer #(
    parameter int ASIZE = 23,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             img_start,
    input  logic [ASIZE-1:0] start_addr,
    input  logic [ASIZE-1:0] max_addr,
    input  logic [CNT_W-1:0] wr_len,
    img_sdram_writer_if.master bus,
    output logic             burst_done,
    output logic             img_done,
    output logic [3:0]       curr_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ACCEPT = 4'd1,
        S_WR_LO  = 4'd2,
        S_WR_HI  = 4'd3,
        S_DONE   = 4'd5
    } state_t;

    state_t           state_q, state_d;
    logic [ASIZE-1:0] curr_addr_q, curr_addr_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [23:0]      pix_q, pix_d;
    logic             ready_q, ready_d;
    logic             wr_req_q, wr_req_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic             burst_q, burst_d;
    logic             done_q, done_d;

    logic             write_go;
    logic [15:0]      word_sel;
    logic [15:0]      word_lo;
    logic [ASIZE-1:0] addr_inc;

`ifdef IMG_WR_RGB888_EN
    logic [15:0]      word_hi;
    assign word_lo = pix_q[23:8];
    assign word_hi = {pix_q[7:0], 8'h00};
`else
    // Low-order colour bits are truncated by RGB565 packing.
    logic pix_unused;
    assign word_lo    = {pix_q[23:19], pix_q[15:10], pix_q[7:3]};
    assign pix_unused = ^{pix_q[18:16], pix_q[9:8], pix_q[2:0]};
`endif

    assign addr_inc = curr_addr_q + ASIZE'(1);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        curr_addr_d = curr_addr_q;
        word_cnt_d  = word_cnt_q;
        pix_d       = pix_q;
        wr_req_d    = 1'b0;
        wr_data_d   = wr_data_q;
        burst_d     = 1'b0;
        write_go    = 1'b0;
        word_sel    = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (img_start) begin
                    curr_addr_d = start_addr;
                    word_cnt_d  = '0;
                    state_d     = (start_addr >= max_addr) ? S_DONE : S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (!img_start) begin
                    state_d = S_IDLE;
                end else if (bus.pixel_valid && ready_q) begin
                    pix_d   = bus.pixel_data;
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: begin
                if (!img_start) begin
                    state_d = S_IDLE;
                end else if (!bus.wr_full) begin
                    write_go = 1'b1;
                    word_sel = word_lo;
`ifdef IMG_WR_RGB888_EN
                    state_d  = S_WR_HI;
`else
                    state_d  = S_ACCEPT;
`endif
                end
            end
`ifdef IMG_WR_RGB888_EN
            S_WR_HI: begin
                if (!img_start) begin
                    state_d = S_IDLE;
                end else if (!bus.wr_full) begin
                    write_go = 1'b1;
                    word_sel = word_hi;
                    state_d  = S_ACCEPT;
                end
            end
`endif
            S_DONE: begin
                if (!img_start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common bookkeeping for every word written. Reaching the last
        // address ends the frame even mid-pixel; a burst boundary on that
        // same word is still flagged.
        if (write_go) begin
            wr_req_d    = 1'b1;
            wr_data_d   = word_sel;
            curr_addr_d = addr_inc;
            if (word_cnt_q == wr_len - CNT_W'(1)) begin
                burst_d    = 1'b1;
                word_cnt_d = '0;
            end else begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
            if (addr_inc == max_addr) begin
                state_d = S_DONE;
            end
        end

        ready_d = (state_d == S_ACCEPT) && !bus.wr_full;
        done_d  = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            curr_addr_q <= '0;
            word_cnt_q  <= '0;
            pix_q       <= '0;
            ready_q     <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_data_q   <= '0;
            burst_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            curr_addr_q <= curr_addr_d;
            word_cnt_q  <= word_cnt_d;
            pix_q       <= pix_d;
            ready_q     <= ready_d;
            wr_req_q    <= wr_req_d;
            wr_data_q   <= wr_data_d;
            burst_q     <= burst_d;
            done_q      <= done_d;
        end
    end

    assign bus.pixel_ready = ready_q;
    assign bus.wr_req      = wr_req_q;
    assign bus.wr_data     = wr_data_q;
    assign burst_done      = burst_q;
    assign img_done        = done_q;
    assign curr_state      = state_q;

endmodule

// File: tb/tb_img_sdram_writer.sv
// Testbench for img_sdram_writer: randomized pixel/backpressure stimulus,
// a frame-level reference model feeding an expected-word queue, and a
// negedge monitor that pops and compares on every wr_req.
`timescale 1ns/1ps
module tb_img_sdram_writer;
    localparam int ASIZE = 23;
    localparam int CNT_W = 11;
`ifdef IMG_WR_RGB888_EN
    localparam int WPP = 2;
`else
    localparam int WPP = 1;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             img_start;
    logic [ASIZE-1:0] start_addr;
    logic [ASIZE-1:0] max_addr;
    logic [CNT_W-1:0] wr_len;
    logic             burst_done;
    logic             img_done;
    logic [3:0]       curr_state;

    img_sdram_writer_if bus ();

    img_sdram_writer #(.ASIZE(ASIZE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .img_start  (img_start),
        .start_addr (start_addr),
        .max_addr   (max_addr),
        .wr_len     (wr_len),
        .bus        (bus),
        .burst_done (burst_done),
        .img_done   (img_done),
        .curr_state (curr_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    int   burst_cnt = 0;
    int   m_pushed = 0;
    int   m_limit = 0;
    int   base_wr = 0;
    int   base_bu = 0;
    int   bp_cnt = 0;
    logic full_rand = 1'b0;
    logic bp_arm = 1'b0;
    logic bp_fired = 1'b0;
    logic full_for_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor + model + wr_full driver ----------------
    // Runs at negedge: checks what the last edge produced, then predicts
    // what the coming edge accepts, then drives wr_full for that edge.
    always @(negedge clk) begin
        logic [15:0] w;
        logic [15:0] wd[2];
        if (bus.wr_req) begin
            wr_cnt++;
            check("wr_while_full", {31'd0, bus.wr_req & full_for_edge}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wr_unexpected: wr_req with data 0x%0h, no word expected at %0t",
                         bus.wr_data, $time);
            end else begin
                w = exp_q.pop_front();
                check("wr_data", {16'd0, bus.wr_data}, {16'd0, w});
            end
        end
        if (burst_done) burst_cnt++;

        if (bp_cnt > 0) begin
            check("bp_wr_req", {31'd0, bus.wr_req}, 32'd0);
            check("bp_ready", {31'd0, bus.pixel_ready}, 32'd0);
            bp_cnt--;
        end
        if (!bp_arm) bp_fired = 1'b0;

        // Frame model: each accepted pixel yields WPP words, capped by the
        // number of addresses in [start_addr, max_addr).
        if (!rst_n || !img_start) begin
            exp_q.delete();
            m_pushed = 0;
        end else if (bus.pixel_valid && bus.pixel_ready) begin
`ifdef IMG_WR_RGB888_EN
            wd[0] = bus.pixel_data[23:8];
            wd[1] = {bus.pixel_data[7:0], 8'h00};
`else
            wd[0] = {bus.pixel_data[23:19], bus.pixel_data[15:10], bus.pixel_data[7:3]};
            wd[1] = 16'h0000;
`endif
            for (int k = 0; k < WPP; k++) begin
                if (m_pushed < m_limit) begin
                    exp_q.push_back(wd[k]);
                    m_pushed++;
                end
            end
        end

        if (bp_cnt > 0) begin
            bus.wr_full = 1'b1;
        end else if (bp_arm && !bp_fired && rst_n && curr_state == 4'd2) begin
            bus.wr_full = 1'b1;
            bp_cnt      = 5;
            bp_fired    = 1'b1;
        end else begin
            bus.wr_full = full_rand && ($urandom_range(0, 3) == 0);
        end
        full_for_edge = bus.wr_full;
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input logic [ASIZE-1:0] s, input logic [ASIZE-1:0] m,
                               input logic [CNT_W-1:0] l);
        start_addr = s;
        max_addr   = m;
        wr_len     = l;
        m_limit    = (m > s) ? int'(m - s) : 0;
        base_wr    = wr_cnt;
        base_bu    = burst_cnt;
        img_start  = 1'b1;
    endtask

    task automatic send_pixels(input int n, input logic fixed, input logic [23:0] d);
        int   cyc;
        logic acc;
        for (int i = 0; i < n; i++) begin
            if (img_done) break;
            if (!fixed) begin
                bus.pixel_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            bus.pixel_valid = 1'b1;
            bus.pixel_data  = fixed ? d : 24'($urandom);
            cyc = 0;
            acc = 1'b0;
            while (!acc && !img_done && cyc < 300) begin
                @(negedge clk);
                if (bus.pixel_ready) acc = 1'b1;
                @(posedge clk); #1;
                cyc++;
            end
            if (!acc) begin
                if (!img_done) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL accept_timeout: pixel %0d not taken within 300 cycles", i);
                end
                break;
            end
        end
        bus.pixel_valid = 1'b0;
    endtask

    task automatic finish_frame();
        int cyc = 0;
        while (!img_done && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("img_done", {31'd0, img_done}, 32'd1);
        @(posedge clk); #1;
        check("leftover_words", exp_q.size(), 32'd0);
        check("write_count", wr_cnt - base_wr, m_limit);
        check("burst_count", burst_cnt - base_bu, m_limit / int'(wr_len));
        check("done_state", {28'd0, curr_state}, 32'd5);
        check("ready_in_done", {31'd0, bus.pixel_ready}, 32'd0);
        img_start = 1'b0;
        @(posedge clk); #1;
        check("idle_state", {28'd0, curr_state}, 32'd0);
        check("done_clear", {31'd0, img_done}, 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wr_req"}, {31'd0, bus.wr_req}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.pixel_ready}, 32'd0);
        check({tag, "_burst"}, {31'd0, burst_done}, 32'd0);
        check({tag, "_done"}, {31'd0, img_done}, 32'd0);
        check({tag, "_state"}, {28'd0, curr_state}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [ASIZE-1:0] s;
        int               sz;
        rst_n           = 1'b0;
        img_start       = 1'b0;
        start_addr      = '0;
        max_addr        = '0;
        wr_len          = 11'd1;
        bus.pixel_valid = 1'b0;
        bus.pixel_data  = '0;

        repeat (3) @(posedge clk);
        #2;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_quiet("post_reset");

        // Directed frame: 8 addresses, bursts of 4, pure red pixels.
        start_frame(23'd0, 23'd8, 11'd4);
        send_pixels(8, 1'b1, 24'hFF0000);
        finish_frame();

        // Backpressure: wr_full held 5 cycles while a word is pending.
        bp_arm = 1'b1;
        start_frame(23'h20, 23'h30, 11'd5);
        send_pixels(100, 1'b0, 24'h0);
        finish_frame();
        bp_arm = 1'b0;

        // Empty frame: start == max gives DONE on the next cycle, no writes.
        start_frame(23'h100, 23'h100, 11'd4);
        @(posedge clk); #1;
        check("empty_state", {28'd0, curr_state}, 32'd5);
        check("empty_done", {31'd0, img_done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("empty_writes", wr_cnt - base_wr, 32'd0);
        finish_frame();

        // Abort after 3 pixels, then rearm the same frame to completion.
        start_frame(23'h40, 23'h48, 11'd3);
        send_pixels(3, 1'b0, 24'h0);
        img_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_state", {28'd0, curr_state}, 32'd0);
        check("abort_done", {31'd0, img_done}, 32'd0);
        check("abort_writes", wr_cnt - base_wr, 2 * WPP);
        start_frame(23'h40, 23'h48, 11'd3);
        send_pixels(100, 1'b0, 24'h0);
        finish_frame();

        // Top of the address space.
        full_rand = 1'b1;
        start_frame(23'h7FFFFA, 23'h7FFFFF, 11'd2);
        send_pixels(100, 1'b0, 24'h0);
        finish_frame();

        // Random frames with random backpressure.
        for (int f = 0; f < 6; f++) begin
            s  = ASIZE'($urandom_range(0, 1000));
            sz = $urandom_range(1, 20);
            start_frame(s, s + ASIZE'(sz), CNT_W'($urandom_range(1, 6)));
            send_pixels(100, 1'b0, 24'h0);
            finish_frame();
        end

        // Asynchronous reset in the middle of a burst.
        full_rand = 1'b0;
        start_frame(23'h200, 23'h210, 11'd4);
        send_pixels(3, 1'b0, 24'h0);
        @(posedge clk);
        #3;
        check("pre_reset_wr_req", {31'd0, bus.wr_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        img_start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset_state", {28'd0, curr_state}, 32'd0);
        start_frame(23'h200, 23'h210, 11'd4);
        send_pixels(100, 1'b0, 24'h0);
        finish_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
